// File: rtl/hv_efuse_load_ctrl_pkg.sv
// Shared HV eFuse load parameters and FSM state encoding.
package hv_efuse_load_ctrl_pkg;

   localparam int unsigned DEF_WORD_NUM  = 8;
   localparam int unsigned DEF_DATA_W    = 8;
   localparam int unsigned DEF_ADDR_W    = 3;
   localparam int unsigned DEF_SETUP_CYC = 2;
   localparam int unsigned DEF_STRB_CYC  = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STRB,
      ST_CAPT,
      ST_CHECK,
      ST_DONE
   } efuse_st_e;

endpackage

// File: rtl/hv_efuse_tmr.sv
// Phase down-counter for the eFuse load sequencer; expire is high while the count is zero.
module hv_efuse_tmr #(
   parameter int unsigned W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         tmr_expire
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - W'(1);
      end
   end

   assign tmr_expire = (cnt == '0);

endmodule

// File: rtl/hv_efuse_load_ctrl.sv
// HV eFuse load sequencer: reads all words, mirrors them into the register file, checks XOR checksum.
// Optional macro EFUSE_LOAD_RETRY_EN adds a single automatic reload on checksum failure.
module hv_efuse_load_ctrl
   import hv_efuse_load_ctrl_pkg::*;
#(
   parameter int unsigned EFUSE_WORD_NUM = DEF_WORD_NUM,
   parameter int unsigned EFUSE_DATA_W   = DEF_DATA_W,
   parameter int unsigned EFUSE_ADDR_W   = DEF_ADDR_W,
   parameter int unsigned SETUP_CYC      = DEF_SETUP_CYC,
   parameter int unsigned STRB_CYC       = DEF_STRB_CYC
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_efuse_load_req,
   input  logic                    i_efuse_abort,
   output logic                    o_efuse_load_done,
   output logic                    o_efuse_busy,
   output logic                    o_efuse_csb,
   output logic                    o_efuse_rden,
   output logic [EFUSE_ADDR_W-1:0] o_efuse_addr,
   input  logic [EFUSE_DATA_W-1:0] i_efuse_rdata,
   output logic                    o_reg_wr_en,
   output logic [EFUSE_ADDR_W-1:0] o_reg_wr_addr,
   output logic [EFUSE_DATA_W-1:0] o_reg_wr_data,
   output logic                    o_efuse_vld,
   output logic                    o_efuse_crc_err
);

   localparam int unsigned TMR_MAX = (SETUP_CYC > STRB_CYC) ? SETUP_CYC : STRB_CYC;
   localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
   localparam logic [TMR_W-1:0] SETUP_VAL = TMR_W'(SETUP_CYC - 1);
   localparam logic [TMR_W-1:0] STRB_VAL  = TMR_W'(STRB_CYC - 1);
   localparam logic [EFUSE_ADDR_W-1:0] LAST_ADDR = EFUSE_ADDR_W'(EFUSE_WORD_NUM - 1);

   efuse_st_e               state;
   logic [EFUSE_DATA_W-1:0] acc;
   logic                    tmr_load;
   logic [TMR_W-1:0]        tmr_val;
   logic                    tmr_expire;
`ifdef EFUSE_LOAD_RETRY_EN
   logic                    retry;
`endif

   // Timer is reloaded on every entry to SETUP or STRB; idle states keep it primed.
   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = SETUP_VAL;
      case (state)
         ST_IDLE, ST_CAPT, ST_CHECK: tmr_load = 1'b1;
         ST_SETUP: begin
            if (tmr_expire) begin
               tmr_load = 1'b1;
               tmr_val  = STRB_VAL;
            end
         end
         default: tmr_load = 1'b0;
      endcase
   end

   hv_efuse_tmr #(.W(TMR_W)) u_tmr (
      .clk        (i_clk),
      .rst        (i_rst),
      .load       (tmr_load),
      .load_val   (tmr_val),
      .tmr_expire (tmr_expire)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state             <= ST_IDLE;
         acc               <= '0;
         o_efuse_load_done <= 1'b0;
         o_efuse_busy      <= 1'b0;
         o_efuse_csb       <= 1'b1;
         o_efuse_rden      <= 1'b0;
         o_efuse_addr      <= '0;
         o_reg_wr_en       <= 1'b0;
         o_reg_wr_addr     <= '0;
         o_reg_wr_data     <= '0;
         o_efuse_vld       <= 1'b0;
         o_efuse_crc_err   <= 1'b0;
`ifdef EFUSE_LOAD_RETRY_EN
         retry             <= 1'b0;
`endif
      end else begin
         o_reg_wr_en       <= 1'b0;
         o_efuse_load_done <= 1'b0;
         if (i_efuse_abort && state != ST_IDLE) begin
            state        <= ST_IDLE;
            o_efuse_busy <= 1'b0;
            o_efuse_csb  <= 1'b1;
            o_efuse_rden <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (i_efuse_load_req) begin
                     state           <= ST_SETUP;
                     o_efuse_busy    <= 1'b1;
                     o_efuse_csb     <= 1'b0;
                     o_efuse_addr    <= '0;
                     acc             <= '0;
                     o_efuse_vld     <= 1'b0;
                     o_efuse_crc_err <= 1'b0;
`ifdef EFUSE_LOAD_RETRY_EN
                     retry           <= 1'b0;
`endif
                  end
               end
               ST_SETUP: begin
                  if (tmr_expire) begin
                     state        <= ST_STRB;
                     o_efuse_rden <= 1'b1;
                  end
               end
               ST_STRB: begin
                  if (tmr_expire) begin
                     state        <= ST_CAPT;
                     o_efuse_rden <= 1'b0;
                  end
               end
               ST_CAPT: begin
                  o_reg_wr_en   <= 1'b1;
                  o_reg_wr_addr <= o_efuse_addr;
                  o_reg_wr_data <= i_efuse_rdata;
                  if (o_efuse_addr == LAST_ADDR) begin
                     state       <= ST_CHECK;
                     o_efuse_csb <= 1'b1;
                  end else begin
                     acc          <= acc ^ i_efuse_rdata;
                     o_efuse_addr <= o_efuse_addr + EFUSE_ADDR_W'(1);
                     state        <= ST_SETUP;
                  end
               end
               ST_CHECK: begin
                  // wr_data still holds the checksum word captured in the preceding CAPT.
                  if (acc == o_reg_wr_data) begin
                     o_efuse_vld       <= 1'b1;
                     o_efuse_load_done <= 1'b1;
                     state             <= ST_DONE;
`ifdef EFUSE_LOAD_RETRY_EN
                  end else if (!retry) begin
                     retry        <= 1'b1;
                     acc          <= '0;
                     o_efuse_addr <= '0;
                     o_efuse_csb  <= 1'b0;
                     state        <= ST_SETUP;
`endif
                  end else begin
                     o_efuse_crc_err   <= 1'b1;
                     o_efuse_load_done <= 1'b1;
                     state             <= ST_DONE;
                  end
               end
               ST_DONE: begin
                  state        <= ST_IDLE;
                  o_efuse_busy <= 1'b0;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_hv_efuse_load_ctrl.sv
// Directed, table-driven bench for hv_efuse_load_ctrl; honours EFUSE_LOAD_RETRY_EN for retry timing.
module tb_hv_efuse_load_ctrl;

   localparam int MAXC = 140;
`ifdef EFUSE_LOAD_RETRY_EN
   localparam int DONE_BAD = 115;
`else
   localparam int DONE_BAD = 58;
`endif

   logic       clk = 1'b0;
   logic       rst, req, abort;
   logic       done, busy, csb, rden, wr_en, vld, crc;
   logic [2:0] addr, wr_addr;
   logic [7:0] rdata, wr_data;

   typedef enum {S_DONE, S_BUSY, S_CSB, S_RDEN, S_ADDR, S_WREN, S_WADDR, S_WDATA, S_VLD, S_CRC} sig_e;
   typedef struct packed {
      logic done, busy, csb, rden, wr_en, vld, crc;
      logic [2:0] addr, wr_addr;
      logic [7:0] wr_data;
   } smp_t;
   typedef struct {
      string       name;
      int          cyc;
      sig_e        sig;
      logic [31:0] exp;
   } vec_t;

   smp_t       tr [0:MAXC];
   vec_t       vecs[$];
   logic [7:0] mem [0:7];
   logic [7:0] good_sum;
   int         n_pass = 0;
   int         n_chk  = 0;

   always #5 clk = ~clk;

   // eFuse macro model: data follows the address while selected.
   always_comb rdata = csb ? 8'h00 : mem[addr];

   hv_efuse_load_ctrl dut (
      .i_clk(clk), .i_rst(rst), .i_efuse_load_req(req), .i_efuse_abort(abort),
      .o_efuse_load_done(done), .o_efuse_busy(busy), .o_efuse_csb(csb), .o_efuse_rden(rden),
      .o_efuse_addr(addr), .i_efuse_rdata(rdata), .o_reg_wr_en(wr_en), .o_reg_wr_addr(wr_addr),
      .o_reg_wr_data(wr_data), .o_efuse_vld(vld), .o_efuse_crc_err(crc)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      else n_pass++;
   endtask

   function automatic logic [31:0] val(input sig_e s, input int c);
      case (s)
         S_DONE:  return 32'(tr[c].done);
         S_BUSY:  return 32'(tr[c].busy);
         S_CSB:   return 32'(tr[c].csb);
         S_RDEN:  return 32'(tr[c].rden);
         S_ADDR:  return 32'(tr[c].addr);
         S_WREN:  return 32'(tr[c].wr_en);
         S_WADDR: return 32'(tr[c].wr_addr);
         S_WDATA: return 32'(tr[c].wr_data);
         S_VLD:   return 32'(tr[c].vld);
         default: return 32'(tr[c].crc);
      endcase
   endfunction

   function automatic int count(input sig_e s, input int lo, input int hi);
      int n = 0;
      for (int c = lo; c <= hi; c++) if (val(s, c) === 32'd1) n++;
      return n;
   endfunction

   function automatic int first_done(input int hi);
      for (int c = 1; c <= hi; c++) if (tr[c].done === 1'b1) return c;
      return -1;
   endfunction

   task automatic add(input string name, input int cyc, input sig_e sig, input logic [31:0] exp);
      vec_t v;
      v.name = name; v.cyc = cyc; v.sig = sig; v.exp = exp;
      vecs.push_back(v);
   endtask

   task automatic apply_vecs(input string tag);
      foreach (vecs[i])
         check($sformatf("%s.%s@%0d", tag, vecs[i].name, vecs[i].cyc), val(vecs[i].sig, vecs[i].cyc), vecs[i].exp);
      vecs.delete();
   endtask

   // Cycle 1 is the cycle after the edge that samples req; tr[k] is sampled mid-cycle k.
   task automatic run_load(input int ncyc, input bit drop_at_done, input int abort_cyc);
      for (int c = 0; c <= MAXC; c++) tr[c] = '0;
      req = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= ncyc; k++) begin
         @(negedge clk);
         tr[k] = '{done, busy, csb, rden, wr_en, vld, crc, addr, wr_addr, wr_data};
         if (drop_at_done && done) req = 1'b0;
         if (abort_cyc != 0 && k == abort_cyc) abort = 1'b1;
         if (abort_cyc != 0 && k == abort_cyc + 1) begin
            abort = 1'b0;
            req   = 1'b0;
         end
      end
   endtask

   task automatic nominal_vecs();
      add("busy", 1, S_BUSY, 1);   add("csb", 1, S_CSB, 0);
      add("addr", 1, S_ADDR, 0);   add("addr", 2, S_ADDR, 0);
      add("rden", 2, S_RDEN, 0);
      for (int c = 3; c <= 6; c++) add("rden", c, S_RDEN, 1);
      add("rden", 7, S_RDEN, 0);   add("csb", 7, S_CSB, 0);
      add("addr", 22, S_ADDR, 3);  add("wr_en", 9, S_WREN, 0);
      for (int w = 0; w < 8; w++) begin
         add("wr_en", 7*w + 8, S_WREN, 1);
         add("wr_addr", 7*w + 8, S_WADDR, 32'(w));
         add("wr_data", 7*w + 8, S_WDATA, 32'(mem[w]));
      end
      add("csb", 57, S_CSB, 1);    add("done", 57, S_DONE, 0);
      add("done", 58, S_DONE, 1);  add("vld", 58, S_VLD, 1);
      add("crc", 58, S_CRC, 0);    add("busy", 59, S_BUSY, 0);
   endtask

   initial begin
      rst = 1'b1; req = 1'b0; abort = 1'b0;
      // The spec's sample words XOR to 0x00, so that is the passing checksum.
      for (int w = 0; w < 7; w++) mem[w] = 8'((w + 1) * 8'h11);
      good_sum = 8'h00;
      for (int w = 0; w < 7; w++) good_sum = good_sum ^ mem[w];
      mem[7] = good_sum;
      repeat (2) @(negedge clk);
      check("rst.csb", 32'(csb), 1);   check("rst.busy", 32'(busy), 0);
      check("rst.done", 32'(done), 0); check("rst.rden", 32'(rden), 0);
      check("rst.wr_en", 32'(wr_en), 0); check("rst.vld", 32'(vld), 0);
      check("rst.crc", 32'(crc), 0);   check("rst.addr", 32'(addr), 0);
      rst = 1'b0;
      @(negedge clk);
      abort = 1'b1;                     // abort in IDLE is ignored
      @(negedge clk);
      abort = 1'b0;

      // Nominal load, req dropped at done: exactly one load.
      run_load(70, 1'b1, 0);
      nominal_vecs();
      add("busy", 60, S_BUSY, 0);
      apply_vecs("nom");
      check("nom.done_cycle", 32'(first_done(70)), 58);
      check("nom.done_cnt", 32'(count(S_DONE, 1, 70)), 1);
      check("nom.wr_cnt", 32'(count(S_WREN, 1, 70)), 8);
      check("nom.rden_cnt", 32'(count(S_RDEN, 1, 70)), 32);

      // Bad checksum.
      mem[7] = good_sum ^ 8'hFF;
      run_load(DONE_BAD + 8, 1'b1, 0);
      add("done", DONE_BAD, S_DONE, 1); add("done", DONE_BAD - 1, S_DONE, 0);
      add("crc", DONE_BAD, S_CRC, 1);   add("vld", DONE_BAD, S_VLD, 0);
      add("crc", DONE_BAD + 3, S_CRC, 1); add("vld", DONE_BAD + 3, S_VLD, 0);
`ifdef EFUSE_LOAD_RETRY_EN
      add("done", 58, S_DONE, 0); add("crc", 58, S_CRC, 0);
      add("csb", 58, S_CSB, 0);   add("wr_addr", 65, S_WADDR, 0);
      add("wr_en", 65, S_WREN, 1);
`endif
      apply_vecs("bad");
      check("bad.done_cnt", 32'(count(S_DONE, 1, DONE_BAD + 8)), 1);
      mem[7] = good_sum;

      // Abort during word 3 strobe (cycles 24..27).
      run_load(45, 1'b0, 25);
      add("crc", 1, S_CRC, 0);   add("rden", 25, S_RDEN, 1);
      add("busy", 26, S_BUSY, 0); add("csb", 26, S_CSB, 1);
      add("rden", 26, S_RDEN, 0); add("vld", 26, S_VLD, 0);
      add("crc", 26, S_CRC, 0);   add("busy", 30, S_BUSY, 0);
      apply_vecs("abort");
      check("abort.wr_cnt", 32'(count(S_WREN, 1, 45)), 3);
      check("abort.done_cnt", 32'(count(S_DONE, 1, 45)), 0);

      // A later request completes a normal load.
      run_load(62, 1'b1, 0);
      nominal_vecs();
      apply_vecs("post_abort");

      // Reset at cycle 20 with req held; a fresh load follows release.
      run_load(20, 1'b0, 0);
      rst = 1'b1;
      #1;
      check("midrst.csb", 32'(csb), 1);   check("midrst.busy", 32'(busy), 0);
      check("midrst.rden", 32'(rden), 0); check("midrst.addr", 32'(addr), 0);
      check("midrst.wr_en", 32'(wr_en), 0);
      @(negedge clk);
      rst = 1'b0;
      run_load(62, 1'b1, 0);
      nominal_vecs();
      apply_vecs("after_rst");

      // Level request held: second load starts right after done, clearing vld.
      run_load(66, 1'b0, 0);
      add("done", 58, S_DONE, 1); add("vld", 59, S_VLD, 1);
      add("busy", 59, S_BUSY, 0); add("busy", 60, S_BUSY, 1);
      add("vld", 60, S_VLD, 0);   add("csb", 60, S_CSB, 0);
      add("addr", 60, S_ADDR, 0); add("wr_addr", 66, S_WADDR, 7);
      apply_vecs("held");
      req = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
